// File: rtl/variance_unit.sv
// variance_unit: buffers one sample block, replays it against the block mean and
// divides the squared-deviation sum by the length. Option: VARIANCE_ROUND_EN.
module variance_unit #(
  parameter int frac_bits = 8,
  parameter int max_len   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_len,
  input  logic [31:0] data_in,
  input  logic        valid,
  input  logic        start_data,
  input  logic [31:0] mean_in,
  input  logic        mean_valid,
  output logic [31:0] variance,
  output logic        variance_valid,
  output logic        busy
);
  localparam int AW    = (max_len > 1) ? $clog2(max_len) : 1;
  localparam int LW    = $clog2(max_len + 1);
  localparam int ACC_W = 64 + $clog2(max_len);
  localparam int AW1   = ACC_W + 1;
  localparam int CW    = $clog2(ACC_W + max_len + 4);

  typedef enum logic [2:0] {
    IDLE, COLLECT, WAIT_MEAN, ACCUM, DIVIDE, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    len_q, len_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] rem_q, rem_d;
  logic [31:0]      mean_q, mean_d;
  logic             mflag_q, mflag_d;
  logic [31:0]      var_q, var_d;
  logic             vv_q, vv_d;
  logic             rd_vld_q, rd_vld_d;
  logic             sq_vld_q, sq_vld_d;
  logic [63:0]      sq_q, sq_d;
  logic [31:0]      rdata_q;

  logic [31:0]      mem [max_len];
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [LW-1:0]    len_in;
  logic [ACC_W-1:0] divisor;
  logic [31:0]      data_sh;
  logic [32:0]      diff;
  logic [31:0]      mag;
  logic [AW1-1:0]   sum;
  logic [AW1-1:0]   rem_sh;
`ifdef VARIANCE_ROUND_EN
  logic [AW1-1:0]   rnd;
`endif

  assign len_in  = (data_len > 32'(max_len)) ? LW'(max_len)
                                             : data_len[LW-1:0];
  assign divisor = ACC_W'(len_q) << frac_bits;
  assign raddr   = cnt_q[AW-1:0];

  // Square path: one stage behind the RAM read.
  always_comb begin
    data_sh  = rdata_q << frac_bits;
    diff     = {1'b0, data_sh} - {1'b0, mean_q};
    mag      = diff[32] ? (~diff[31:0] + 32'd1) : diff[31:0];
    sq_d     = 64'(mag) * 64'(mag);
    rd_vld_d = (state_q == ACCUM) && (cnt_q < CW'(len_q));
    sq_vld_d = rd_vld_q;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    mean_d  = mean_q;
    mflag_d = mflag_q;
    var_d   = var_q;
    vv_d    = 1'b0;
    we      = 1'b0;
    waddr   = cnt_q[AW-1:0];
    sum     = '0;
    rem_sh  = {rem_q, acc_q[ACC_W-1]};
`ifdef VARIANCE_ROUND_EN
    rnd     = '0;
`endif
    if (state_q != IDLE && mean_valid) begin
      mean_d  = mean_in;
      mflag_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start_data && valid && data_len != 32'd0) begin
          we      = 1'b1;
          waddr   = '0;
          len_d   = len_in;
          acc_d   = '0;
          mflag_d = 1'b0;
          cnt_d   = CW'(1);
          state_d = (len_in == LW'(1)) ? WAIT_MEAN : COLLECT;
        end
      end
      COLLECT: begin
        if (valid) begin
          we    = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == CW'(len_q)) begin
            cnt_d   = '0;
            state_d = (mflag_q || mean_valid) ? ACCUM : WAIT_MEAN;
          end
        end
      end
      WAIT_MEAN: begin
        if (mflag_q) begin
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (sq_vld_q) begin
          sum   = {1'b0, acc_q} + AW1'(sq_q);
          acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        end
        if (cnt_q == CW'(len_q) + CW'(1)) begin
`ifdef VARIANCE_ROUND_EN
          rnd   = {1'b0, acc_d} + {1'b0, divisor >> 1};
          acc_d = rnd[ACC_W] ? '1 : rnd[ACC_W-1:0];
`endif
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIVIDE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DIVIDE: begin
        // acc shifts out the dividend and shifts in quotient bits.
        if (rem_sh >= AW1'(divisor)) begin
          rem_d = ACC_W'(rem_sh - AW1'(divisor));
          acc_d = {acc_q[ACC_W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[ACC_W-1:0];
          acc_d = {acc_q[ACC_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ACC_W - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        var_d   = (|acc_q[ACC_W-1:32]) ? '1 : acc_q[31:0];
        vv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      mean_q   <= '0;
      mflag_q  <= 1'b0;
      var_q    <= '0;
      vv_q     <= 1'b0;
      rd_vld_q <= 1'b0;
      sq_vld_q <= 1'b0;
      sq_q     <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      mean_q   <= mean_d;
      mflag_q  <= mflag_d;
      var_q    <= var_d;
      vv_q     <= vv_d;
      rd_vld_q <= rd_vld_d;
      sq_vld_q <= sq_vld_d;
      sq_q     <= sq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= data_in;
    rdata_q <= mem[raddr];
  end

  assign variance       = var_q;
  assign variance_valid = vv_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_variance_unit.sv
// tb_variance_unit: directed and randomized blocks checked against a plain
// arithmetic model of the block variance.
`timescale 1ns/1ps
module tb_variance_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_len = '0;
  logic [31:0] data_in = '0;
  logic [31:0] mean_in = '0;
  logic        valid = 1'b0;
  logic        start_data = 1'b0;
  logic        mean_valid = 1'b0;
  logic [31:0] variance;
  logic        variance_valid;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] smp[$];

  variance_unit dut (
    .clk(clk), .reset(reset), .data_len(data_len),
    .data_in(data_in), .valid(valid), .start_data(start_data),
    .mean_in(mean_in), .mean_valid(mean_valid),
    .variance(variance), .variance_valid(variance_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_var(input int len,
                                            input logic [31:0] mean);
    int leff;
    logic [127:0] acc;
    logic [127:0] dv;
    logic [127:0] q;
    leff = (len > 64) ? 64 : len;
    acc = '0;
    for (int i = 0; i < leff; i++) begin
      longint d;
      longint m;
      d = (longint'(smp[i]) << 8) - longint'(mean);
      m = (d < 0) ? -d : d;
      acc += 128'(m) * 128'(m);
    end
    dv = 128'(leff) * 128'(256);
`ifdef VARIANCE_ROUND_EN
    acc += dv / 2;
`endif
    q = acc / dv;
    return (q > 128'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
  endfunction

  task automatic run_block(input int len, input logic [31:0] mean,
      input int mean_at, input int pre_at, input logic [31:0] pre_val,
      input bit glitch, output logic [31:0] o_var, output int o_lat,
      output bit o_busy, output bit o_width);
    int n;
    n = smp.size();
    o_var = 'x; o_lat = -1; o_busy = 1'b0; o_width = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b1;
      data_in = smp[i];
      data_len = 32'(len);
      start_data = (i == 0) || (glitch && i == 1);
      mean_valid = (i == mean_at) || (i == pre_at);
      mean_in = (i == pre_at) ? pre_val : mean;
    end
    if (mean_at < 0) begin
      @(negedge clk);
      valid = 1'b0; start_data = 1'b0; mean_valid = 1'b0;
      @(negedge clk);
      mean_valid = 1'b1; mean_in = mean;
    end
    for (int j = 1; j <= 400; j++) begin
      @(negedge clk);
      valid = 1'b0; start_data = 1'b0; mean_valid = 1'b0;
      if (glitch && j == 20) begin
        valid = 1'b1; start_data = 1'b1;
        data_len = 32'd4; data_in = 32'd7;
      end
      if (j == 1) o_busy = busy;
      if (variance_valid) begin
        o_lat = j;
        o_var = variance;
        @(negedge clk);
        o_width = !variance_valid;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (variance !== 32'd0)
      $display("FAIL reset_variance got %0d want 0", variance);
    else n_pass++;
    n_total++;
    if (variance_valid !== 1'b0)
      $display("FAIL reset_valid got %b want 0", variance_valid);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0)
      $display("FAIL reset_busy got %b want 0", busy);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_constant();
    logic [31:0] v; int lat; bit b; bit w;
    smp = '{32'd3, 32'd3, 32'd3, 32'd3};
    run_block(4, 32'd768, -1, -1, 32'd0, 1'b0, v, lat, b, w);
    n_total++;
    if (v !== 32'd0) $display("FAIL const_var got %0d want 0", v);
    else n_pass++;
    n_total++;
    if (lat !== 4 + 2 + 70 + 1 + 2)
      $display("FAIL const_latency got %0d want %0d", lat, 79);
    else n_pass++;
    n_total++;
    if (b !== 1'b1) $display("FAIL const_busy got %b want 1", b);
    else n_pass++;
    n_total++;
    if (w !== 1'b1) $display("FAIL const_pulse_width got %b want 1", w);
    else n_pass++;
  endtask

  task automatic test_ramp();
    logic [31:0] v; int lat; bit b; bit w;
    smp = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_block(4, 32'd640, -1, -1, 32'd0, 1'b0, v, lat, b, w);
    n_total++;
    if (v !== 32'd320) $display("FAIL ramp_var got %0d want 320", v);
    else n_pass++;
    n_total++;
    if (v !== model_var(4, 32'd640))
      $display("FAIL ramp_model got %0d want %0d", v, model_var(4, 640));
    else n_pass++;
  endtask

  task automatic test_rounding();
    logic [31:0] v; logic [31:0] exp_v; int lat; bit b; bit w;
`ifdef VARIANCE_ROUND_EN
    exp_v = 32'd57;
`else
    exp_v = 32'd56;
`endif
    smp = '{32'd0, 32'd0, 32'd1};
    run_block(3, 32'd85, -1, -1, 32'd0, 1'b0, v, lat, b, w);
    n_total++;
    if (v !== exp_v) $display("FAIL round_var got %0d want %0d", v, exp_v);
    else n_pass++;
  endtask

  task automatic test_early_mean();
    logic [31:0] v; int lat; bit b; bit w;
    smp = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_block(4, 32'd640, 1, -1, 32'd0, 1'b0, v, lat, b, w);
    n_total++;
    if (v !== 32'd320) $display("FAIL early_var got %0d want 320", v);
    else n_pass++;
    n_total++;
    if (lat !== 4 + 2 + 70 + 1 + 1)
      $display("FAIL early_latency got %0d want %0d", lat, 78);
    else n_pass++;
    run_block(4, 32'd640, 2, 1, 32'd0, 1'b0, v, lat, b, w);
    n_total++;
    if (v !== 32'd320) $display("FAIL override_var got %0d want 320", v);
    else n_pass++;
    n_total++;
    if (lat !== 78)
      $display("FAIL override_latency got %0d want 78", lat);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    logic [31:0] v; int lat; bit b; bit w;
    smp = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_block(4, 32'd640, -1, -1, 32'd0, 1'b1, v, lat, b, w);
    n_total++;
    if (v !== 32'd320) $display("FAIL glitch_var got %0d want 320", v);
    else n_pass++;
    n_total++;
    if (lat !== 79) $display("FAIL glitch_latency got %0d want 79", lat);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_total++;
    if (variance !== 32'd320 || busy !== 1'b0)
      $display("FAIL hold_var got %0d busy %b want 320 busy 0",
               variance, busy);
    else n_pass++;
  endtask

  task automatic test_abort();
    int pulses;
    logic [31:0] v; int lat; bit b; bit w;
    smp = '{32'd1, 32'd2, 32'd3, 32'd4};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid = 1'b1; data_in = smp[i];
      data_len = 32'd4; start_data = (i == 0);
    end
    @(negedge clk);
    valid = 1'b0; start_data = 1'b0;
    @(negedge clk);
    mean_valid = 1'b1; mean_in = 32'd640;
    @(negedge clk);
    mean_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_total++;
    if (variance !== 32'd0 || variance_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_outputs got var %0d vv %b busy %b want 0 0 0",
               variance, variance_valid, busy);
    else n_pass++;
    pulses = 0;
    for (int j = 0; j < 150; j++) begin
      @(negedge clk);
      if (variance_valid) pulses++;
    end
    n_total++;
    if (pulses !== 0) $display("FAIL abort_pulse got %0d want 0", pulses);
    else n_pass++;
    run_block(4, 32'd640, -1, -1, 32'd0, 1'b0, v, lat, b, w);
    n_total++;
    if (v !== 32'd320) $display("FAIL after_abort got %0d want 320", v);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    bit seen;
    @(negedge clk);
    valid = 1'b1; start_data = 1'b1;
    data_len = 32'd0; data_in = 32'd9;
    @(negedge clk);
    valid = 1'b0; start_data = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL zero_len_busy got %b want 0", busy);
    else n_pass++;
    seen = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (busy || variance_valid) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0)
      $display("FAIL zero_len_idle got %b want 0", seen);
    else n_pass++;
  endtask

  task automatic test_clip();
    logic [31:0] v; int lat; bit b; bit w;
    smp.delete();
    for (int i = 0; i < 100; i++)
      smp.push_back((i < 64) ? 32'd5 : 32'd77);
    run_block(100, 32'd1280, -1, -1, 32'd0, 1'b0, v, lat, b, w);
    n_total++;
    if (v !== 32'd0) $display("FAIL clip_var got %0d want 0", v);
    else n_pass++;
    n_total++;
    if (lat !== 64 + 75)
      $display("FAIL clip_latency got %0d want %0d", lat, 139);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] v; logic [31:0] mean; logic [31:0] exp_v;
    int lat; bit b; bit w; int len; int mat; bit wide;
    for (int t = 0; t < 16; t++) begin
      len = int'($urandom_range(1, 72));
      wide = ($urandom_range(0, 3) == 0);
      smp.delete();
      for (int i = 0; i < len; i++)
        smp.push_back(wide ? $urandom_range(0, 32'h00FF_FFFF)
                           : $urandom_range(0, 15));
      mean = wide ? $urandom() : $urandom_range(0, 16 * 256);
      mat = -1;
      if (len >= 2 && $urandom_range(0, 1) == 1)
        mat = int'($urandom_range(1, (len > 64 ? 64 : len) - 1));
      exp_v = model_var(len, mean);
      run_block(len, mean, mat, -1, 32'd0, 1'b0, v, lat, b, w);
      n_total++;
      if (v !== exp_v)
        $display("FAIL random_%0d len %0d got %0d want %0d",
                 t, len, v, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_rounding();
    test_early_mean();
    test_start_ignored();
    test_abort();
    test_zero_len();
    test_clip();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
